mult_rr_sched: RTL and testbench
================================

Name: mult_rr_sched

Overview:
- Round-robin scheduler that shares one registered 64x64 unsigned multiplier among NREQ requesters.
- The multiplier has a synchronous reset and a registered 128-bit product, with MULT_LAT cycles from operand to product.
- The block accepts at most one operand pair per cycle, drives the multiplier operand buses and tracks in-flight operations by requester ID.
- Each product is returned into a per-requester response slot with a valid/ready handshake.
- It sits between the client blocks and the shared multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..16)
MULT_LAT, 1, cycles from operands presented to product valid on mul_c (1..8)
IDW, $clog2(NREQ), width of internal requester ID

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester operand pair valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_a  input  NREQ*64  packed operand A, requester i at [64*i+:64]
req_b  input  NREQ*64  packed operand B, same packing
resp_valid  output  NREQ  per-requester result valid
resp_ready  input  NREQ  per-requester result consumed
resp_c  output  NREQ*128  packed 128-bit products, requester i at [128*i+:128]
mul_a  output  64  operand A to the shared multiplier
mul_b  output  64  operand B to the shared multiplier
mul_c  input  128  product from the shared multiplier

Behaviour:
- Eligibility: requester i is eligible when req_valid[i]=1, no op for i is in flight, and resp_valid[i]=0 or resp_ready[i]=1 this cycle. This gives at most one outstanding result per requester, so response slots never overflow.
- Grant: combinational round-robin over the eligible set, starting from pointer ptr.
  - req_ready[gnt]=1 in the same cycle.
  - req_ready may depend on req_valid.
- Accept: req_valid[i] & req_ready[i] at a rising edge.
  - ptr <= (gnt+1) mod NREQ.
  - If no grant that cycle, ptr is unchanged.
- Operand drive: mul_a/mul_b = req_a/req_b of the granted requester, combinational; all zero when there is no grant.
- In-flight tracking: shift register of MULT_LAT stages, each holding {valid, id}. Stage 0 loads {accept, gnt} every cycle; a bubble loads valid=0.
- Capture:
  - When the last stage is valid with id k, resp_c[k] <= mul_c and resp_valid[k] <= 1 at the same edge.
  - Latency: accept at the edge ending cycle T gives resp_valid in cycle T+1+MULT_LAT. With MULT_LAT=1 this is a 2-cycle turnaround.
- Response handshake:
  - resp_valid[k] clears at an edge where resp_ready[k]=1, unless a new capture for k happens at the same edge; capture wins and valid stays 1.
  - resp_c[k] holds stable while resp_valid[k]=1 and resp_ready[k]=0.
- Throughput: one op per cycle sustained when at least one requester is eligible. A single requester with resp_ready tied high issues once every MULT_LAT+1 cycles, because of the in-flight block.
- Arithmetic: unsigned; 64x64 gives the full 128-bit product, no truncation.
- Reset (synchronous, including mid-operation):
  - ptr=0, all in-flight stages invalid, resp_valid=0, resp_c=0.
  - Ops in flight are discarded. The shared multiplier must use the same rst so that mul_c=0.
  - req_ready=0 during the reset cycle.
- Boundary cases:
  - All requesters valid: grants rotate 0,1,2,3,0...
  - ptr wraps NREQ-1 to 0.
  - A requester that drops req_valid without a grant is legal; there is no starvation because the pointer advances past each granted requester.

Optional Feature:
- Macro MULT_RR_SCHED_STATS_EN.
- When defined:
  - Adds output port op_count (32 bits), the total number of accepted ops.
  - Adds output port stall_count (32 bits), the number of cycles with any req_valid=1 and no grant.
  - Both counters are saturating at 32'hFFFFFFFF and cleared by rst.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then requester 0 only: a=3, b=5 -> req_ready[0]=1 at cycle 0, resp_valid[0]=1 at cycle 2 (MULT_LAT=1), resp_c[0]=15.
- All 4 valid continuously, resp_ready=4'hF -> grant order 0,1,2,3,0,1...; each requester i gets a=i+1, b=2^64-1 and receives resp_c=(i+1)*(2^64-1); one grant per cycle once slots allow.
- Max operands a=b=64'hFFFFFFFFFFFFFFFF -> resp_c=128'hFFFFFFFFFFFFFFFE0000000000000001.
- Requester 2 holds resp_ready[2]=0 for 10 cycles -> resp_c[2] stays stable, requester 2 gets no grant, and the others keep rotating. On release, requester 2 gets its next grant in the same cycle that resp_ready[2]=1.
- Assert rst one cycle after accepting ops for requesters 1 and 3 -> no resp_valid in the following cycles, ptr=0, and the next grant after reset goes to the lowest eligible requester.
- With MULT_RR_SCHED_STATS_EN: 8 accepts plus 3 stalled cycles -> op_count=8, stall_count=3; rst clears both to 0.

Source files
------------

// File: rtl/mult_rr_sched.sv
// Round-robin front end for one shared registered 64x64 multiplier; tracks in-flight ops by requester.
// Optional statistics counters are enabled with `define MULT_RR_SCHED_STATS_EN.
module mult_rr_sched #(
    parameter int NREQ     = 4,
    parameter int MULT_LAT = 1,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*64-1:0]   req_a,
    input  logic [NREQ*64-1:0]   req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [NREQ*128-1:0]  resp_c,
    output logic [63:0]          mul_a,
    output logic [63:0]          mul_b,
    input  logic [127:0]         mul_c
`ifdef MULT_RR_SCHED_STATS_EN
    ,
    output logic [31:0]          op_count,
    output logic [31:0]          stall_count
`endif
);

    logic [IDW-1:0]               ptr_q, ptr_d;
    logic [MULT_LAT-1:0]          stg_vld_q, stg_vld_d;
    logic [MULT_LAT-1:0][IDW-1:0] stg_id_q, stg_id_d;
    logic [NREQ-1:0]              resp_valid_q, resp_valid_d;
    logic [NREQ*128-1:0]          resp_c_q, resp_c_d;

    logic [NREQ-1:0]   busy;
    logic [NREQ-1:0]   elig;
    logic [2*NREQ-1:0] elig_dbl;
    logic [NREQ-1:0]   elig_rot;
    logic [IDW:0]      gnt_off;
    logic [IDW:0]      gnt_sum;
    logic              gnt_vld;
    logic [IDW-1:0]    gnt_id;

    // A requester with an op anywhere in the pipeline is blocked until its result lands.
    always_comb begin
        busy = '0;
        for (int s = 0; s < MULT_LAT; s++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (stg_vld_q[s] && (stg_id_q[s] == IDW'(i))) begin
                    busy[i] = 1'b1;
                end
            end
        end
    end

    assign elig = req_valid & ~busy & (~resp_valid_q | resp_ready) & {NREQ{~rst}};

    // Rotate so bit 0 is the pointer position, pick the first set bit, then rotate back.
    always_comb begin
        elig_dbl = {elig, elig} >> ptr_q;
        elig_rot = elig_dbl[NREQ-1:0];
        gnt_vld  = 1'b0;
        gnt_off  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                gnt_vld = 1'b1;
                gnt_off = (IDW+1)'(i);
            end
        end
        gnt_sum = {1'b0, ptr_q} + gnt_off;
        if (gnt_sum >= (IDW+1)'(NREQ)) begin
            gnt_sum = gnt_sum - (IDW+1)'(NREQ);
        end
        gnt_id = gnt_sum[IDW-1:0];
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld && (gnt_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
                mul_a        = req_a[64*i +: 64];
                mul_b        = req_b[64*i +: 64];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end

        stg_vld_d    = stg_vld_q;
        stg_id_d     = stg_id_q;
        stg_vld_d[0] = gnt_vld;
        stg_id_d[0]  = gnt_id;
        for (int s = 1; s < MULT_LAT; s++) begin
            stg_vld_d[s] = stg_vld_q[s-1];
            stg_id_d[s]  = stg_id_q[s-1];
        end
    end

    // A capture at the same edge as a consume keeps the slot valid with the new product.
    always_comb begin
        resp_valid_d = resp_valid_q & ~resp_ready;
        resp_c_d     = resp_c_q;
        for (int i = 0; i < NREQ; i++) begin
            if (stg_vld_q[MULT_LAT-1] && (stg_id_q[MULT_LAT-1] == IDW'(i))) begin
                resp_valid_d[i]         = 1'b1;
                resp_c_d[128*i +: 128]  = mul_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            stg_vld_q    <= '0;
            stg_id_q     <= '0;
            resp_valid_q <= '0;
            resp_c_q     <= '0;
        end else begin
            ptr_q        <= ptr_d;
            stg_vld_q    <= stg_vld_d;
            stg_id_q     <= stg_id_d;
            resp_valid_q <= resp_valid_d;
            resp_c_q     <= resp_c_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_c     = resp_c_q;

`ifdef MULT_RR_SCHED_STATS_EN
    logic [31:0] op_count_q, op_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        op_count_d    = op_count_q;
        stall_count_d = stall_count_q;
        if (gnt_vld && (op_count_q != 32'hFFFF_FFFF)) begin
            op_count_d = op_count_q + 32'd1;
        end
        if ((|req_valid) && !gnt_vld && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            op_count_q    <= op_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign op_count    = op_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_mult_rr_sched.sv
// Directed self-checking bench for mult_rr_sched (NREQ=4, MULT_LAT=1) with a registered multiplier model.
module tb_mult_rr_sched;

    localparam int NREQ   = 4;
    localparam int TB_LAT = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*64-1:0] req_a;
    logic [NREQ*64-1:0] req_b;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready;
    logic [NREQ*128-1:0] resp_c;
    logic [63:0]        mul_a;
    logic [63:0]        mul_b;
    logic [127:0]       mul_c;
`ifdef MULT_RR_SCHED_STATS_EN
    logic [31:0]        op_count;
    logic [31:0]        stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_rr_sched #(.NREQ(NREQ), .MULT_LAT(TB_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_c     (resp_c),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c      (mul_c)
`ifdef MULT_RR_SCHED_STATS_EN
        ,
        .op_count   (op_count),
        .stall_count(stall_count)
`endif
    );

    // Shared multiplier model: registered product, same synchronous reset.
    logic [127:0] mpipe [TB_LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TB_LAT; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= {64'b0, mul_a} * {64'b0, mul_b};
            for (int i = 1; i < TB_LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_c = mpipe[TB_LAT-1];

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = 4'hF;
        resp_ready = 4'hF;
        req_a      = {4{64'h1234}};
        req_b      = {4{64'h5678}};
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected %b", req_ready, 4'b0000);
        end
        n_checks++;
        if (mul_a !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mul_a: got %h expected 0", mul_a);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid);
        end
        n_checks++;
        if (resp_c !== '0) begin
            n_fail++;
            $display("FAIL reset_resp_c: got %h expected 0", resp_c);
        end
    endtask

    task automatic test_single();
        apply_reset();
        resp_ready   = 4'hF;
        req_valid    = 4'b0001;
        req_a[63:0]  = 64'd3;
        req_b[63:0]  = 64'd5;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_gnt_c0: got %b expected 0001", req_ready);
        end
        n_checks++;
        if ({mul_a, mul_b} !== {64'd3, 64'd5}) begin
            n_fail++;
            $display("FAIL single_operands: got a=%h b=%h expected a=3 b=5", mul_a, mul_b);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_inflight_c1: got %b expected 0000", req_ready);
        end
        n_checks++;
        if (resp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_resp_early_c1: got %b expected 0000", resp_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_resp_valid_c2: got %b expected 0001", resp_valid);
        end
        n_checks++;
        if (resp_c[127:0] !== 128'd15) begin
            n_fail++;
            $display("FAIL single_resp_c_c2: got %h expected f", resp_c[127:0]);
        end
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_reissue_c2: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_rotate();
        logic [3:0]   exp_rdy;
        logic [127:0] exp_c;
        int           k;
        apply_reset();
        resp_ready = 4'hF;
        req_valid  = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            req_a[64*i +: 64] = 64'(i + 1);
            req_b[64*i +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        for (int c = 0; c < 10; c++) begin
            #1;
            exp_rdy = 4'(1 << (c % 4));
            n_checks++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rot_gnt c%0d: got %b expected %b", c, req_ready, exp_rdy);
            end
            n_checks++;
            if (mul_a !== 64'((c % 4) + 1)) begin
                n_fail++;
                $display("FAIL rot_mul_a c%0d: got %h expected %h", c, mul_a, (c % 4) + 1);
            end
            if (c >= 2) begin
                k     = (c - 2) % 4;
                exp_c = 128'(k + 1) * 128'(64'hFFFF_FFFF_FFFF_FFFF);
                n_checks++;
                if (resp_valid !== 4'(1 << k)) begin
                    n_fail++;
                    $display("FAIL rot_resp_valid c%0d: got %b expected %b", c, resp_valid, 4'(1 << k));
                end
                n_checks++;
                if (resp_c[128*k +: 128] !== exp_c) begin
                    n_fail++;
                    $display("FAIL rot_resp_c c%0d: got %h expected %h", c, resp_c[128*k +: 128], exp_c);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_max();
        apply_reset();
        resp_ready         = 4'hF;
        req_valid          = 4'b0010;
        req_a[127:64]      = 64'hFFFF_FFFF_FFFF_FFFF;
        req_b[127:64]      = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL max_gnt: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL max_resp_valid: got %b expected 0010", resp_valid);
        end
        n_checks++;
        if (resp_c[255:128] !== 128'hFFFFFFFFFFFFFFFE0000000000000001) begin
            n_fail++;
            $display("FAIL max_resp_c: got %h expected fffffffffffffffe0000000000000001", resp_c[255:128]);
        end
    endtask

    task automatic test_backpressure();
        int gtab [16] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1, 3, 0, 1, 2};
        apply_reset();
        resp_ready = 4'b1011;
        req_valid  = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            req_a[64*i +: 64] = 64'(i + 10);
            req_b[64*i +: 64] = 64'(i + 1);
        end
        for (int c = 0; c < 16; c++) begin
            if (c == 15) resp_ready = 4'hF;
            #1;
            n_checks++;
            if (req_ready !== 4'(1 << gtab[c])) begin
                n_fail++;
                $display("FAIL bp_gnt c%0d: got %b expected %b", c, req_ready, 4'(1 << gtab[c]));
            end
            if (c >= 4) begin
                n_checks++;
                if (resp_valid[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold_valid c%0d: got %b expected 1", c, resp_valid[2]);
                end
                n_checks++;
                if (resp_c[383:256] !== 128'd36) begin
                    n_fail++;
                    $display("FAIL bp_hold_c c%0d: got %h expected 24", c, resp_c[383:256]);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        resp_ready      = 4'b0000;
        req_valid       = 4'b1000;
        req_a[255:192]  = 64'd7;
        req_b[255:192]  = 64'd7;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL rmid_gnt3: got %b expected 1000", req_ready);
        end
        @(negedge clk);
        req_valid      = 4'b0010;
        req_a[127:64]  = 64'd2;
        req_b[127:64]  = 64'd2;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rmid_gnt1: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'hF;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_ready_in_rst: got %b expected 0000", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_resp_valid_c3: got %b expected 0000", resp_valid);
        end
        n_checks++;
        if (resp_c !== '0) begin
            n_fail++;
            $display("FAIL rmid_resp_c_c3: got %h expected 0", resp_c);
        end
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rmid_ptr_gnt: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_resp_valid_c4: got %b expected 0000", resp_valid);
        end
        n_checks++;
        if (resp_c[255:128] !== 128'd0) begin
            n_fail++;
            $display("FAIL rmid_discard_c4: got %h expected 0", resp_c[255:128]);
        end
    endtask

`ifdef MULT_RR_SCHED_STATS_EN
    task automatic test_stats();
        apply_reset();
        resp_ready = 4'hF;
        req_valid  = 4'b0001;
        repeat (6) @(negedge clk);
        req_valid = 4'hF;
        repeat (5) @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        n_checks++;
        if (op_count !== 32'd8) begin
            n_fail++;
            $display("FAIL stats_op_count: got %0d expected 8", op_count);
        end
        n_checks++;
        if (stall_count !== 32'd3) begin
            n_fail++;
            $display("FAIL stats_stall_count: got %0d expected 3", stall_count);
        end
        apply_reset();
        #1;
        n_checks++;
        if ({op_count, stall_count} !== 64'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got op=%0d stall=%0d expected 0 0", op_count, stall_count);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        test_reset();
        test_single();
        test_rotate();
        test_max();
        test_backpressure();
        test_reset_mid();
`ifdef MULT_RR_SCHED_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
